// File: rtl/chal_mem_arbiter.sv
// chal_mem_arbiter
// Shares the single-port challenge RAM between the peripheral bus and the attestation engine.
// The bus has absolute priority and never waits. The engine streams a burst of words through
// a valid/ready port. While a burst is active the challenge is locked and bus writes are
// dropped, so the words being attested cannot change mid-read.
//
// Ports:
//   mclk, puc_rst        clock, synchronous active-high reset
//   bus_en/we/addr/din   peripheral access (bus_we == 0 means read)
//   bus_dout             read data, valid the cycle after a bus read, 0 otherwise
//   bus_wr_blocked       pulse: a bus write was dropped because the challenge is locked
//   eng_req/start/len    burst request (sampled in idle only)
//   eng_abort            cancel the current burst
//   eng_data/valid/ready streamed word, valid/ready handshake
//   eng_busy, chal_lock  burst active
//   eng_done, eng_err    pulses: burst completed / request with illegal length
//   ram_*                RAM port (active-low enables, read data one cycle after access)
module chal_mem_arbiter #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CHAL_WORDS = 16
) (
  input  logic              mclk,
  input  logic              puc_rst,
  // Peripheral bus
  input  logic              bus_en,
  input  logic [1:0]        bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [15:0]       bus_din,
  output logic [15:0]       bus_dout,
  output logic              bus_wr_blocked,
  // Attestation engine
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_start,
  input  logic [ADDR_W:0]   eng_len,
  input  logic              eng_abort,
  output logic [15:0]       eng_data,
  output logic              eng_valid,
  input  logic              eng_ready,
  output logic              eng_busy,
  output logic              eng_done,
  output logic              eng_err,
  output logic              chal_lock,
  // RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cen,
  output logic [1:0]        ram_wen,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam logic [ADDR_W:0] LenMax = (ADDR_W + 1)'(CHAL_WORDS);
  localparam logic [ADDR_W:0] LenOne = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  // An engine read returns exactly one cycle after issue, so the in-flight flag doubles as
  // the engine source tag for the returning data.
  logic              eng_inflight_q;
  logic              bus_tag_q;
  logic [15:0]       eng_data_q;
  logic              eng_valid_q;
  logic              eng_done_q;
  logic              eng_err_q;
  logic              wr_blocked_q;

  logic busy;
  logic bus_wr_req;
  logic bus_rd;
  logic bus_wr;
  logic bus_blk;
  logic bus_slot;
  logic eng_hs;
  logic eng_rd;
  logic len_ok;
  logic abort;

  assign busy       = (state_q != StIdle);
  assign bus_wr_req = bus_en & (bus_we != 2'b00);
  assign bus_rd     = bus_en & (bus_we == 2'b00);
  assign bus_wr     = bus_wr_req & ~busy;
  // A dropped write does not occupy the RAM, so the engine may use that cycle.
  assign bus_blk    = bus_wr_req & busy;
  assign bus_slot   = bus_rd | bus_wr;
  assign eng_hs     = eng_valid_q & eng_ready;
  // Only issue when the output register is free (or being emptied) so a return never
  // overwrites an unaccepted word.
  assign eng_rd     = (state_q == StRun) & ~bus_slot & ~eng_inflight_q &
                      (~eng_valid_q | eng_ready);
  assign len_ok     = (eng_len != '0) && (eng_len <= LenMax);
  assign abort      = busy & eng_abort;

  // RAM arbitration: bus read, bus write, engine read, else idle.
  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = 2'b11;
    ram_addr = '0;
    ram_din  = '0;
    if (!puc_rst) begin
      if (bus_rd) begin
        ram_cen  = 1'b0;
        ram_addr = bus_addr;
      end else if (bus_wr) begin
        ram_cen  = 1'b0;
        ram_wen  = ~bus_we;
        ram_addr = bus_addr;
        ram_din  = bus_din;
      end else if (eng_rd) begin
        ram_cen  = 1'b0;
        ram_addr = ptr_q;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      rem_q          <= '0;
      eng_inflight_q <= 1'b0;
      bus_tag_q      <= 1'b0;
      eng_data_q     <= '0;
      eng_valid_q    <= 1'b0;
      eng_done_q     <= 1'b0;
      eng_err_q      <= 1'b0;
      wr_blocked_q   <= 1'b0;
    end else begin
      bus_tag_q    <= bus_rd;
      wr_blocked_q <= bus_blk;
      eng_done_q   <= 1'b0;
      eng_err_q    <= 1'b0;

      // Abort discards the returning word and wins over a simultaneous handshake.
      eng_inflight_q <= abort ? 1'b0 : eng_rd;
      if (abort) begin
        eng_valid_q <= 1'b0;
      end else if (eng_inflight_q) begin
        eng_valid_q <= 1'b1;
        eng_data_q  <= ram_dout;
      end else if (eng_hs) begin
        eng_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (eng_req) begin
            if (len_ok) begin
              ptr_q   <= eng_start;
              rem_q   <= eng_len;
              state_q <= StRun;
            end else begin
              eng_err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (eng_abort) begin
            state_q <= StIdle;
          end else if (eng_rd) begin
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - 1'b1;
            if (rem_q == LenOne) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Only the last word can be outstanding here; finish once it is accepted.
          if (eng_abort) begin
            state_q <= StIdle;
          end else if (eng_hs && !eng_inflight_q) begin
            state_q    <= StIdle;
            eng_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_dout       = bus_tag_q ? ram_dout : 16'h0000;
  assign bus_wr_blocked = wr_blocked_q;
  assign eng_data       = eng_data_q;
  assign eng_valid      = eng_valid_q;
  assign eng_busy       = busy;
  assign chal_lock      = busy;
  assign eng_done       = eng_done_q;
  assign eng_err        = eng_err_q;

endmodule

// File: tb/tb_chal_mem_arbiter.sv
// Directed bench for chal_mem_arbiter with a behavioural single-port RAM.
module tb_chal_mem_arbiter;

  localparam int AW = 4;

  logic          mclk = 1'b0;
  logic          puc_rst;
  logic          bus_en;
  logic [1:0]    bus_we;
  logic [AW-1:0] bus_addr;
  logic [15:0]   bus_din;
  logic [15:0]   bus_dout;
  logic          bus_wr_blocked;
  logic          eng_req;
  logic [AW-1:0] eng_start;
  logic [AW:0]   eng_len;
  logic          eng_abort;
  logic [15:0]   eng_data;
  logic          eng_valid;
  logic          eng_ready;
  logic          eng_busy;
  logic          eng_done;
  logic          eng_err;
  logic          chal_lock;
  logic [AW-1:0] ram_addr;
  logic          ram_cen;
  logic [1:0]    ram_wen;
  logic [15:0]   ram_din;
  logic [15:0]   ram_dout;

  int nchecks = 0;
  int nerr    = 0;

  chal_mem_arbiter #(
    .ADDR_W    (AW),
    .CHAL_WORDS(16)
  ) dut (
    .mclk          (mclk),
    .puc_rst       (puc_rst),
    .bus_en        (bus_en),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_din       (bus_din),
    .bus_dout      (bus_dout),
    .bus_wr_blocked(bus_wr_blocked),
    .eng_req       (eng_req),
    .eng_start     (eng_start),
    .eng_len       (eng_len),
    .eng_abort     (eng_abort),
    .eng_data      (eng_data),
    .eng_valid     (eng_valid),
    .eng_ready     (eng_ready),
    .eng_busy      (eng_busy),
    .eng_done      (eng_done),
    .eng_err       (eng_err),
    .chal_lock     (chal_lock),
    .ram_addr      (ram_addr),
    .ram_cen       (ram_cen),
    .ram_wen       (ram_wen),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout)
  );

  always #5 mclk = ~mclk;

  // Single-port RAM: byte writes, read data registered one cycle after the access.
  logic [15:0] mem [16];
  always @(posedge mclk) begin
    if (!ram_cen) begin
      if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  // Runs one burst and checks every word in order.
  // bus_mode: 0 no bus traffic, 1 blocked write to word 0, 2 bus read every other cycle.
  task automatic burst(input int start, input int len, input int stall_at, input int stall_n,
                       input int bus_mode, input bit chk_gap);
    int          k;
    int          last_c;
    int          stall_left;
    int          done_cnt;
    int          done_c;
    logic        pend;
    logic [15:0] pend_exp;
    logic [15:0] wexp;
    k          = 0;
    last_c     = -1;
    stall_left = stall_n;
    done_cnt   = 0;
    done_c     = 0;
    pend       = 1'b0;
    pend_exp   = '0;
    eng_start  = AW'(start);
    eng_len    = (AW + 1)'(len);
    eng_req    = 1'b1;
    eng_ready  = 1'b1;
    cyc();
    eng_req = 1'b0;
    chk("busy_after_req", {31'd0, eng_busy}, 32'd1);
    chk("lock_after_req", {31'd0, chal_lock}, 32'd1);
    for (int c = 0; c < 200; c++) begin
      if (pend) begin
        chk("bus_rd_in_burst", {16'd0, bus_dout}, {16'd0, pend_exp});
        pend = 1'b0;
      end
      if (bus_mode == 1 && c == 2) chk("wr_blocked_pulse", {31'd0, bus_wr_blocked}, 32'd1);
      if (bus_mode == 1 && c == 3) chk("wr_blocked_clear", {31'd0, bus_wr_blocked}, 32'd0);
      bus_en = 1'b0;
      bus_we = 2'b00;
      if (done_cnt == 0 && bus_mode == 1 && c == 1) begin
        bus_en   = 1'b1;
        bus_we   = 2'b11;
        bus_addr = 4'd0;
        bus_din  = 16'hDEAD;
      end
      if (done_cnt == 0 && bus_mode == 2 && (c % 2) == 1) begin
        bus_en   = 1'b1;
        bus_we   = 2'b00;
        bus_addr = AW'((c * 7) % 16);
        pend     = 1'b1;
        pend_exp = 16'h1000 + 16'((c * 7) % 16);
      end
      if (eng_done) begin
        done_cnt++;
        done_c = c;
        chk("busy_with_done", {31'd0, eng_busy}, 32'd0);
        chk("words_at_done", k, len);
      end
      if (eng_valid && k < len) begin
        wexp = 16'h1000 + 16'((start + k) % 16);
        if (k == stall_at && stall_left > 0) begin
          eng_ready = 1'b0;
          stall_left--;
          chk("stall_hold", {16'd0, eng_data}, {16'd0, wexp});
        end else begin
          eng_ready = 1'b1;
          chk("word", {16'd0, eng_data}, {16'd0, wexp});
          if (chk_gap && k > 0) chk("word_gap", c - last_c, 32'd2);
          last_c = c;
          k++;
        end
      end else if (eng_valid) begin
        chk("extra_word", {31'd0, eng_valid}, 32'd0);
        eng_ready = 1'b1;
      end else begin
        eng_ready = 1'b1;
      end
      if (done_cnt > 0 && c >= done_c + 3) break;
      cyc();
    end
    bus_en = 1'b0;
    chk("burst_word_count", k, len);
    chk("burst_done_count", done_cnt, 32'd1);
    chk("burst_busy_end", {31'd0, eng_busy}, 32'd0);
  endtask

  initial begin
    puc_rst   = 1'b1;
    bus_en    = 1'b0;
    bus_we    = 2'b00;
    bus_addr  = '0;
    bus_din   = '0;
    eng_req   = 1'b0;
    eng_start = '0;
    eng_len   = '0;
    eng_abort = 1'b0;
    eng_ready = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_bus_dout", {16'd0, bus_dout}, 32'd0);
    chk("rst_wr_blocked", {31'd0, bus_wr_blocked}, 32'd0);
    chk("rst_eng_valid", {31'd0, eng_valid}, 32'd0);
    chk("rst_eng_data", {16'd0, eng_data}, 32'd0);
    chk("rst_flags", {28'd0, eng_busy, eng_done, eng_err, chal_lock}, 32'd0);
    chk("rst_ram_ctl", {29'd0, ram_cen, ram_wen}, 32'd7);
    chk("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
    chk("rst_ram_din", {16'd0, ram_din}, 32'd0);
    puc_rst = 1'b0;

    // Fill the challenge over the bus, then read it back
    for (int i = 0; i < 16; i++) begin
      bus_en   = 1'b1;
      bus_we   = 2'b11;
      bus_addr = AW'(i);
      bus_din  = 16'h1000 + 16'(i);
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      bus_en   = 1'b1;
      bus_we   = 2'b00;
      bus_addr = AW'(i);
      cyc();
      chk("bus_readback", {16'd0, bus_dout}, 32'h1000 + i);
      chk("eng_quiet", {29'd0, eng_valid, eng_busy, eng_done}, 32'd0);
    end
    bus_en = 1'b0;
    cyc();
    chk("bus_dout_idle", {16'd0, bus_dout}, 32'd0);

    // Plain burst, ready always high
    burst(2, 4, -1, 0, 0, 1'b1);
    // Wrapping burst with a 3-cycle stall on the second word
    burst(14, 4, 1, 3, 0, 1'b0);
    // Bus write during a burst is dropped
    burst(0, 4, -1, 0, 1, 1'b0);
    bus_en   = 1'b1;
    bus_we   = 2'b00;
    bus_addr = 4'd0;
    cyc();
    bus_en = 1'b0;
    chk("word0_unchanged", {16'd0, bus_dout}, 32'h1000);
    // Full-length burst with interleaved bus reads
    burst(0, 16, -1, 0, 2, 1'b0);

    // Illegal lengths
    eng_len = 5'd0;
    eng_req = 1'b1;
    cyc();
    eng_req = 1'b0;
    chk("err_len0", {30'd0, eng_err, eng_busy}, 32'd2);
    cyc();
    chk("err_len0_pulse", {31'd0, eng_err}, 32'd0);
    eng_len = 5'd17;
    eng_req = 1'b1;
    cyc();
    eng_req = 1'b0;
    chk("err_len17", {30'd0, eng_err, eng_busy}, 32'd2);
    cyc();
    chk("err_len17_pulse", {31'd0, eng_err}, 32'd0);

    // Abort with a read in flight
    eng_ready = 1'b0;
    eng_start = 4'd5;
    eng_len   = 5'd3;
    eng_req   = 1'b1;
    cyc();
    eng_req = 1'b0;
    chk("abort_busy_before", {31'd0, eng_busy}, 32'd1);
    cyc();
    eng_abort = 1'b1;
    cyc();
    eng_abort = 1'b0;
    chk("abort_idle", {30'd0, eng_busy, eng_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_quiet", {29'd0, eng_valid, eng_done, eng_busy}, 32'd0);
      cyc();
    end
    burst(7, 1, -1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
